adc_frame_packetizer: RTL and testbench

ADC_FRAME_PACKETIZER -- requirements
Module: adc_frame_packetizer

---
 rtl/adc_pkt_pkg.sv | 7 +
 rtl/axis_out_reg.sv | 43 ++++
 rtl/adc_frame_packetizer.sv | 131 +++++++++++++
 tb/tb_adc_frame_packetizer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkt_pkg.sv
// adc_pkt_pkg: shared state enum and constants for the ADC frame packetizer
package adc_pkt_pkg;
  typedef enum logic {IDLE, PAY} state_e;
  localparam logic [15:0] MAGIC_DEFAULT = 16'hAD18;
  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_HALF = 8'h0F;
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: one-entry valid/ready register slice; accepts a new beat when empty or draining
module axis_out_reg #(
  parameter int W = 64,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [W-1:0]  s_data_i,
  input  logic [KW-1:0] s_keep_i,
  input  logic          s_last_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [W-1:0]  m_data_o,
  output logic [KW-1:0] m_keep_o,
  output logic          m_last_o
);
  logic          vld_q;
  logic [W-1:0]  data_q;
  logic [KW-1:0] keep_q;
  logic          last_q;
  assign s_ready_o = !vld_q || m_ready_i;
  assign m_valid_o = vld_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (s_ready_o) begin
      vld_q <= s_valid_i;
      if (s_valid_i) begin
        data_q <= s_data_i;
        keep_q <= s_keep_i;
        last_q <= s_last_i;
      end
    end
  end
endmodule

// File: rtl/adc_frame_packetizer.sv
// adc_frame_packetizer: packs 32-bit ADC samples into 64-bit frame beats with tlast/flush handling.
// Define PACKETIZER_HEADER_EN to prefix each frame with a {MAGIC, FRAME_WORDS, seq} header beat.
module adc_frame_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int          FRAME_WORDS = 64,
  parameter int          WIDTH       = 64,
  parameter int          KEEP_WIDTH  = 8,
  parameter logic [15:0] MAGIC       = MAGIC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [31:0]           s_sample_tdata,
  input  logic                  s_sample_tvalid,
  output logic                  s_sample_tready,
  output logic [WIDTH-1:0]      m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tuser,
  input  logic                  m_tready,
  output logic [31:0]           frame_seq,
  output logic                  status_frame_done
);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [15:0] FW16 = 16'(FRAME_WORDS);
`ifdef PACKETIZER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  state_e                  state_q, state_d;
  logic [WIDTH/2-1:0]      half_q, half_d;
  logic [WIDTH-1:0]        hold_q, hold_d, push_data, hdr_word;
  logic                    half_vld_q, half_vld_d, hold_vld_q, hold_vld_d, fp_q, fp_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic [31:0]             frame_seq_q, frame_seq_d;
  logic [KEEP_WIDTH-1:0]   push_keep;
  logic                    out_rdy, push, push_last;
  logic                    last_word, need_push, s_fire, close_req, close_now, end_frame;
  // In PAY exactly one of half/hold is occupied, so a sample needs at most one output push
  assign last_word       = half_vld_q && wcnt_q == CW'(FRAME_WORDS - 1);
  assign need_push       = half_vld_q ? last_word : (hold_vld_q || (HDR && state_q == IDLE));
  assign s_sample_tready = enable && !fp_q && (!need_push || out_rdy);
  assign s_fire          = s_sample_tvalid && s_sample_tready;
  assign close_req       = fp_q || (flush && (state_q == PAY || s_fire) && !(s_fire && last_word));
  assign close_now       = close_req && out_rdy && !(s_fire && need_push);
  assign end_frame       = (s_fire && last_word) || close_now;
  assign hdr_word        = {MAGIC, FW16, frame_seq_q};
  assign frame_seq       = frame_seq_q;
  assign m_tuser         = 1'b0;
  assign status_frame_done = m_tvalid && m_tready && m_tlast;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = end_frame ? IDLE : (s_fire ? PAY : state_q);
  end
  always_comb begin
    half_d      = half_q;
    half_vld_d  = half_vld_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    push        = 1'b0;
    push_data   = hold_q;
    push_keep   = KEEP_FULL;
    push_last   = 1'b0;
    if (s_fire && half_vld_q) begin
      half_vld_d = 1'b0;
      hold_d     = {s_sample_tdata, half_q};
      hold_vld_d = !last_word;
      push       = last_word;
      push_last  = last_word;
      push_data  = {s_sample_tdata, half_q};
    end else if (s_fire) begin
      half_d     = s_sample_tdata;
      half_vld_d = 1'b1;
      hold_vld_d = 1'b0;
      push       = need_push;
      push_data  = hold_vld_q ? hold_q : hdr_word;
    end
    // A close sees the post-sample contents so a coincident sample lands in the closing beat
    if (close_now) begin
      push       = 1'b1;
      push_last  = 1'b1;
      push_data  = hold_vld_d ? hold_d : {{(WIDTH/2){1'b0}}, half_d};
      push_keep  = hold_vld_d ? KEEP_FULL : KEEP_HALF;
      half_vld_d = 1'b0;
      hold_vld_d = 1'b0;
    end
    fp_d        = close_req && !close_now;
    wcnt_d      = end_frame ? '0 : wcnt_q + CW'(s_fire && half_vld_q);
    frame_seq_d = frame_seq_q + 32'(end_frame);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q      <= '0;
      half_vld_q  <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      fp_q        <= 1'b0;
      wcnt_q      <= '0;
      frame_seq_q <= '0;
    end else begin
      half_q      <= half_d;
      half_vld_q  <= half_vld_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      fp_q        <= fp_d;
      wcnt_q      <= wcnt_d;
      frame_seq_q <= frame_seq_d;
    end
  end
  axis_out_reg #(.W(WIDTH), .KW(KEEP_WIDTH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (push),
    .s_ready_o (out_rdy),
    .s_data_i  (push_data),
    .s_keep_i  (push_keep),
    .s_last_i  (push_last),
    .m_valid_o (m_tvalid),
    .m_ready_i (m_tready),
    .m_data_o  (m_tdata),
    .m_keep_o  (m_tkeep),
    .m_last_o  (m_tlast)
  );
endmodule

// File: tb/tb_adc_frame_packetizer.sv
// tb_adc_frame_packetizer: random and directed stimulus against a frame-level reference model
module tb_adc_frame_packetizer;
  localparam int FW = 4;
`ifdef PACKETIZER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flush = 1'b0;
  logic [31:0] s_sample_tdata = '0;
  logic        s_sample_tvalid = 1'b0, s_sample_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tuser, status_frame_done;
  logic        m_tready = 1'b0;
  logic [31:0] frame_seq;
  int          n_tests = 0, n_fail = 0;
  logic [72:0] obs[$], exp_q[$];
  logic [31:0] frm[$];
  logic [31:0] seq_m = '0;
  int          frames_m = 0, done_cnt = 0;
  bit          took = 1'b0, stall_q = 1'b0;
  logic [72:0] prev_beat = '0;
  always #5 clk = ~clk;
  adc_frame_packetizer #(.FRAME_WORDS(FW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .flush             (flush),
    .s_sample_tdata    (s_sample_tdata),
    .s_sample_tvalid   (s_sample_tvalid),
    .s_sample_tready   (s_sample_tready),
    .m_tdata           (m_tdata),
    .m_tkeep           (m_tkeep),
    .m_tvalid          (m_tvalid),
    .m_tlast           (m_tlast),
    .m_tuser           (m_tuser),
    .m_tready          (m_tready),
    .frame_seq         (frame_seq),
    .status_frame_done (status_frame_done)
  );
  task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  // Expected beats of one frame: optional header, sample pairs low-first, odd tail zero-padded
  function automatic void close_frame();
    if (HDR) exp_q.push_back({1'b0, 8'hFF, 16'hAD18, 16'(FW), seq_m});
    for (int i = 0; i < frm.size(); i += 2) begin
      if (i + 1 < frm.size()) exp_q.push_back({i + 2 >= frm.size(), 8'hFF, frm[i+1], frm[i]});
      else exp_q.push_back({1'b1, 8'h0F, 32'h0, frm[i]});
    end
    seq_m++;
    frames_m++;
    frm.delete();
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      took = s_sample_tvalid && s_sample_tready;
      if (took) begin
        frm.push_back(s_sample_tdata);
        if (frm.size() == 2 * FW) close_frame();
        else if (flush) close_frame();
      end else if (flush && frm.size() > 0) close_frame();
      if (m_tvalid && m_tready) obs.push_back({m_tlast, m_tkeep, m_tdata});
      if (status_frame_done) done_cnt++;
      if (stall_q) chk("hold_stable", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev_beat});
      stall_q = m_tvalid && !m_tready;
      prev_beat = {m_tlast, m_tkeep, m_tdata};
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d);
    int n = 0;
    s_sample_tvalid = 1'b1;
    s_sample_tdata = d;
    @(negedge clk);
    while (!s_sample_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("send_timeout", 73'(s_sample_tready), 73'(1));
    tick(1);
    s_sample_tvalid = 1'b0;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask
  task automatic run(input int n, input int pv, input int pr, input int pf, input int pe);
    for (int i = 0; i < n; i++) begin
      if (!s_sample_tvalid || took) begin
        s_sample_tvalid = $urandom_range(99) < pv;
        s_sample_tdata = $urandom;
      end
      flush = $urandom_range(999) < pf;
      enable = $urandom_range(99) < pe;
      m_tready = $urandom_range(99) < pr;
      tick(1);
    end
    flush = 1'b0;
  endtask
  task automatic check_phase(input string tag);
    s_sample_tvalid = 1'b0;
    m_tready = 1'b1;
    enable = 1'b1;
    tick(2);
    do_flush();
    tick(8);
    chk({tag, "_beats"}, 73'(obs.size()), 73'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), obs[i], exp_q[i]);
    chk({tag, "_seq"}, 73'(frame_seq), 73'(seq_m));
    chk({tag, "_done"}, 73'(done_cnt), 73'(frames_m));
    chk({tag, "_tuser"}, 73'(m_tuser), 73'(0));
    obs.delete();
    exp_q.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int tl;
    #2;
    chk("rst_tvalid", 73'(m_tvalid), 73'(0));
    chk("rst_tlast", 73'(m_tlast), 73'(0));
    chk("rst_tdata", 73'(m_tdata), 73'(0));
    chk("rst_tkeep", 73'(m_tkeep), 73'(0));
    chk("rst_done", 73'(status_frame_done), 73'(0));
    chk("rst_seq", 73'(frame_seq), 73'(0));
    #10 rst_n = 1'b1;
    tick(1);
    enable = 1'b1;
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(i));
    check_phase("basic");
    send(32'hA);
    send(32'hB);
    send(32'hC);
    do_flush();
    check_phase("flush_odd");
    send(32'h21);
    send(32'h22);
    s_sample_tdata = 32'h23;
    s_sample_tvalid = 1'b1;
    flush = 1'b1;
    tick(1);
    s_sample_tvalid = 1'b0;
    flush = 1'b0;
    check_phase("flush_coin");
    send(32'h11);
    send(32'h12);
    m_tready = 1'b0;
    run(20, 100, 0, 0, 100);
    chk("stall_tready", 73'(s_sample_tready), 73'(0));
    check_phase("stall");
    for (int k = 0; k < 6; k++) begin
      run(300, $urandom_range(40, 100), $urandom_range(20, 100), $urandom_range(0, 30), $urandom_range(60, 100));
      check_phase($sformatf("rand%0d", k));
    end
    force dut.frame_seq_q = 32'hFFFFFFFF;
    #2;
    release dut.frame_seq_q;
    seq_m = 32'hFFFFFFFF;
    tick(1);
    chk("seq_forced", 73'(frame_seq), 73'(32'hFFFFFFFF));
    for (int i = 0; i < 8; i++) send(32'h50 + 32'(i));
    check_phase("wrap");
    send(32'h1);
    send(32'h2);
    m_tready = 1'b0;
    send(32'h3);
    tick(1);
    chk("pre_rst_valid", 73'(m_tvalid), 73'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 73'(m_tvalid), 73'(0));
    chk("arst_tdata", 73'(m_tdata), 73'(0));
    chk("arst_tkeep", 73'(m_tkeep), 73'(0));
    chk("arst_seq", 73'(frame_seq), 73'(0));
    tl = 0;
    foreach (obs[i]) tl += int'(obs[i][72]);
    chk("abort_no_tlast", 73'(tl), 73'(0));
    obs.delete();
    exp_q.delete();
    frm.delete();
    seq_m = '0;
    frames_m = 0;
    done_cnt = 0;
    stall_q = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_tready = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i));
    check_phase("post_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
